// File: rtl/radix4_booth_pkg.sv
// Shared types for the radix-4 Booth sequencing controller.
// FSM state encoding and the shift-count helper.
package radix4_booth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPT,
        RESP
    } booth_seq_state_e;

    function automatic int num_shifts(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/radix4_booth_seq_ctrl.sv
// Sequencing controller in front of the radix-4 Booth datapath.
// Define RADIX4_BOOTH_SEQ_RESULT_REG_EN to register the product (adds a CAPT cycle).
module radix4_booth_seq_ctrl
    import radix4_booth_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit CHECK_PARAM = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy,
    output logic                 dp_start,
    output logic                 dp_en,
    output logic                 dp_rst_cntr_n,
    output logic [WIDTH-1:0]     dp_multiplier,
    output logic [WIDTH-1:0]     dp_multiplicand,
    input  logic                 dp_done,
    input  logic [2*WIDTH-1:0]   dp_result
);

    localparam int N  = num_shifts(WIDTH);
    localparam int CW = $clog2(N) + 1;

    generate
        if (CHECK_PARAM && ((WIDTH % 2) != 0 || WIDTH < 4)) begin : g_bad_width
            $fatal(1, "radix4_booth_seq_ctrl: WIDTH must be even and >= 4");
        end
    endgenerate

    booth_seq_state_e state;
    logic [CW-1:0]    run_cnt;
    logic             accept;
    logic             run_last;

    assign in_ready = !clr && (state == IDLE || (state == RESP && out_ready));
    assign accept   = in_valid && in_ready;
    assign run_last = (run_cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            run_cnt         <= '0;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            dp_start        <= 1'b0;
            dp_en           <= 1'b0;
            dp_rst_cntr_n   <= 1'b0;
            dp_multiplier   <= '0;
            dp_multiplicand <= '0;
        end else if (clr) begin
            state         <= IDLE;
            run_cnt       <= '0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            dp_start      <= 1'b0;
            dp_en         <= 1'b0;
            dp_rst_cntr_n <= 1'b0;
        end else begin
            if (accept) begin
                dp_multiplier   <= in_a;
                dp_multiplicand <= in_b;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= LOAD;
                        dp_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    state         <= RUN;
                    run_cnt       <= '0;
                    dp_start      <= 1'b0;
                    dp_en         <= 1'b1;
                    dp_rst_cntr_n <= 1'b1;
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    // Leave on done, or on the budget so a stuck datapath cannot hang us
                    if (dp_done || run_last) begin
                        dp_en         <= 1'b0;
                        dp_rst_cntr_n <= 1'b0;
`ifdef RADIX4_BOOTH_SEQ_RESULT_REG_EN
                        state <= CAPT;
`else
                        state     <= RESP;
                        out_valid <= 1'b1;
`endif
                    end
                end
                CAPT: begin
                    state     <= RESP;
                    out_valid <= 1'b1;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            state    <= LOAD;
                            dp_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RADIX4_BOOTH_SEQ_RESULT_REG_EN
    logic [2*WIDTH-1:0] out_prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_prod_q <= '0;
        end else if (!clr && state == CAPT) begin
            out_prod_q <= dp_result;
        end
    end

    assign out_prod = out_prod_q;
`else
    assign out_prod = out_valid ? dp_result : '0;
`endif

    always @(posedge clk) begin
        if (rst_n && !clr && state == RUN && run_last) begin
            assert (dp_done);
        end
    end

endmodule

// File: tb/tb_radix4_booth_seq_ctrl.sv
// Scoreboard bench for radix4_booth_seq_ctrl, paired with a behavioural
// radix-4 Booth datapath model; directed vectors with hand-computed products.
module tb_radix4_booth_seq_ctrl;

    localparam int W = 8;
    localparam int N = 4;
`ifdef RADIX4_BOOTH_SEQ_RESULT_REG_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_prod;
    logic          busy;
    logic          dp_start;
    logic          dp_en;
    logic          dp_rst_cntr_n;
    logic [W-1:0]  dp_multiplier;
    logic [W-1:0]  dp_multiplicand;
    logic          dp_done;
    logic [2*W-1:0] dp_result;

    radix4_booth_seq_ctrl #(.WIDTH(W), .CHECK_PARAM(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
        .busy(busy), .dp_start(dp_start), .dp_en(dp_en),
        .dp_rst_cntr_n(dp_rst_cntr_n),
        .dp_multiplier(dp_multiplier), .dp_multiplicand(dp_multiplicand),
        .dp_done(dp_done), .dp_result(dp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural radix-4 Booth datapath: one recoded digit per enabled cycle
    logic [2*W-1:0] acc;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2:0]     cntr;

    function automatic logic [2*W-1:0] booth_term(logic [W-1:0] a, logic [W-1:0] b, int i);
        logic [W:0] ext;
        logic [2:0] tr;
        int d;
        ext = {a, 1'b0};
        tr  = ext[2*i +: 3];
        case (tr)
            3'b001, 3'b010: d = 1;
            3'b011:         d = 2;
            3'b100:         d = -2;
            3'b101, 3'b110: d = -1;
            default:        d = 0;
        endcase
        return 16'((d * int'($signed(b))) <<< (2 * i));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            ra   <= '0;
            rb   <= '0;
            cntr <= '0;
        end else begin
            if (dp_start) begin
                acc <= '0;
                ra  <= dp_multiplier;
                rb  <= dp_multiplicand;
            end else if (dp_en) begin
                acc <= acc + booth_term(ra, rb, int'(cntr));
            end
            if (!dp_rst_cntr_n) cntr <= '0;
            else if (dp_en) cntr <= cntr + 3'd1;
        end
    end

    assign dp_done   = (cntr == 3'd3);
    assign dp_result = acc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int en_cnt = 0;
    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];
    bit             seen = 0;
    logic [2*W-1:0] held;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Edge bookkeeping: handshakes retire, clr drops the in-flight op
    always @(posedge clk) begin
        cyc++;
        if (dp_en) en_cnt++;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
                seen = 0;
            end else if (clr) begin
                exp_q.delete();
                acc_q.delete();
                seen = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else if (!seen) begin
                seen = 1;
                chk("latency", 32'(cyc - acc_q[0]), 32'(LAT));
                chk("product", 32'(out_prod), 32'(exp_q[0]));
                chk("en_cycles", 32'(en_cnt), 32'(N));
                held = out_prod;
            end else begin
                chk("prod_hold", 32'(out_prod), 32'(held));
            end
        end
    end

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] e, logic ordy);
        int t;
        t = 0;
        @(negedge clk);
        out_ready = ordy;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        en_cnt = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
    endtask

    task automatic wait_drain(string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || busy)
            chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_en(string name);
        int t;
        t = 0;
        while (!dp_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!dp_en) chk(name, 32'(dp_en), 32'd1);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_prod"}, 32'(out_prod), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_dp_start"}, 32'(dp_start), 32'd0);
        chk({tag, "_dp_en"}, 32'(dp_en), 32'd0);
        chk({tag, "_dp_rst_cntr_n"}, 32'(dp_rst_cntr_n), 32'd0);
        chk({tag, "_dp_multiplier"}, 32'(dp_multiplier), 32'd0);
        chk({tag, "_dp_multiplicand"}, 32'(dp_multiplicand), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        issue(8'sd7, -8'sd3, 16'hFFEB, 1'b1);
        wait_drain("drain_7x-3");
        issue(8'h80, 8'h80, 16'h4000, 1'b1);
        wait_drain("drain_min_min");
        issue(8'sd127, 8'sd127, 16'h3F01, 1'b1);
        wait_drain("drain_max_max");
        issue(8'sd5, 8'sd6, 16'h001E, 1'b1);
        wait_drain("drain_5x6");

        // Stalled response, then back-to-back accept on the handshake edge
        issue(-8'sd5, 8'sd9, 16'hFFD3, 1'b0);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        chk("stall_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        issue(8'sd2, 8'sd3, 16'h0006, 1'b1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_dp_start", 32'(dp_start), 32'd1);
        wait_drain("drain_b2b");

        // clr in the second RUN cycle aborts the op
        issue(8'sd3, 8'sd4, 16'h000C, 1'b1);
        wait_en("clr_en_timeout");
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_dp_en", 32'(dp_en), 32'd0);
        chk("clr_dp_rst_cntr_n", 32'(dp_rst_cntr_n), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("clr_no_valid", 32'(out_valid), 32'd0);
        end

        // A request coinciding with clr is refused
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_no_accept", 32'(busy), 32'd0);

        issue(8'hFF, 8'sd1, 16'hFFFF, 1'b1);
        wait_drain("drain_after_clr");

        // Asynchronous reset mid-run
        issue(8'sd6, 8'sd7, 16'h002A, 1'b1);
        wait_en("rst_en_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        exp_q.delete();
        acc_q.delete();
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_no_valid", 32'(out_valid), 32'd0);
        end

        issue(-8'sd8, -8'sd8, 16'h0040, 1'b1);
        wait_drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
